// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite compositor: game states, screen size,
// sprite geometry and placement, and the 16-colour palette.
package sprite_pkg;

   typedef enum logic [1:0] {
      GS_START = 2'd0,
      GS_PLAY  = 2'd1,
      GS_OVER  = 2'd2
   } game_state_t;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;

   localparam int BIRD_W   = 40;
   localparam int BIRD_H   = 40;
   localparam int PIPE_W   = 80;
   localparam int PIPE_H   = SCREEN_H;

   localparam int START_W  = 140;
   localparam int START_H  = 40;
   localparam int START_X  = 250;
   localparam int START_Y  = 100;

   localparam int END_W    = 230;
   localparam int END_H    = 40;
   localparam int END_X    = 205;
   localparam int END_Y    = 200;

   // Index 0 doubles as the transparent key for every layer except background.
   localparam logic [23:0] PALETTE [16] = '{
      24'h000000, 24'hFFFFFF, 24'h70C5CE, 24'hDED895,
      24'h73BF2E, 24'hF8B733, 24'hE0802C, 24'hD8382E,
      24'h543847, 24'h558022, 24'h9CE659, 24'hFAFAFA,
      24'hFC3800, 24'h5EE270, 24'hE7E7E7, 24'h3B2C32
   };

endpackage

// File: rtl/sprite_hit.sv
// Rectangle hit test: flags whether a screen position falls inside a W x H
// sprite placed at (org_x, org_y) and returns its row-major ROM address (0 on miss).
module sprite_hit #(
   parameter int W      = 40,
   parameter int H      = 40,
   parameter int ADDR_W = 11
) (
   input  logic signed [11:0] pos_x,
   input  logic signed [11:0] pos_y,
   input  logic signed [11:0] org_x,
   input  logic signed [11:0] org_y,
   output logic               hit,
   output logic [ADDR_W-1:0]  addr
);

   localparam logic signed [11:0] W_S = 12'(W);
   localparam logic signed [11:0] H_S = 12'(H);
   localparam logic [ADDR_W-1:0]  W_A = ADDR_W'(W);

   logic signed [11:0] col;
   logic signed [11:0] row;

   // 12-bit signed differences cannot wrap for any 10-bit screen coordinate.
   assign col  = pos_x - org_x;
   assign row  = pos_y - org_y;
   assign hit  = (col >= 12'sd0) && (col < W_S) && (row >= 12'sd0) && (row < H_S);
   assign addr = hit ? (ADDR_W'(row) * W_A + ADDR_W'(col)) : '0;

endmodule

// File: rtl/sprite_compositor.sv
// Three-stage sprite compositor: S1 hit tests and ROM addresses, S2 ROM data
// return, S3 layer select and palette lookup. Define SPRITE_COMP_FLASH_EN to flash the end banner.
module sprite_compositor
   import sprite_pkg::*;
(
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic [9:0]         DrawX,
   input  logic [9:0]         DrawY,
   input  logic               pixel_valid,
   input  logic [9:0]         BirdX,
   input  logic [8:0]         BirdY,
   input  logic signed [10:0] PipeX,
   input  logic [8:0]         GapY,
   input  logic [1:0]         game_state,
   output logic [10:0]        bird_addr,
   output logic [18:0]        bgd_addr,
   output logic [15:0]        pipe_addr,
   output logic [12:0]        start_addr,
   output logic [13:0]        end_addr,
   input  logic [2:0]         bird_data,
   input  logic [3:0]         bgd_data,
   input  logic [3:0]         pipe_data,
   input  logic [3:0]         start_data,
   input  logic [3:0]         end_data,
   output logic [7:0]         Red,
   output logic [7:0]         Green,
   output logic [7:0]         Blue,
   output logic               rgb_valid
);

   localparam logic signed [11:0] ROW_WRAP = 12'(SCREEN_H);

   logic signed [11:0] pos_x;
   logic signed [11:0] pos_y;
   logic signed [11:0] pipe_row_raw;
   logic signed [11:0] pipe_row;
   logic [18:0]        bgd_lin;
   logic               bird_hit, pipe_hit, start_hit, end_hit;
   logic               start_on, end_on, end_show;
   logic [10:0]        bird_lin;
   logic [15:0]        pipe_lin;
   logic [12:0]        start_lin;
   logic [13:0]        end_lin;

   assign pos_x = $signed({2'b00, DrawX});
   assign pos_y = $signed({2'b00, DrawY});

   // Pipe image is a full-height column scrolled so its gap centre sits at GapY.
   assign pipe_row_raw = pos_y + 12'sd240 - $signed({3'b000, GapY});

   always_comb begin
      pipe_row = pipe_row_raw;
      if (pipe_row_raw < 12'sd0)
         pipe_row = pipe_row_raw + ROW_WRAP;
      else if (pipe_row_raw >= ROW_WRAP)
         pipe_row = pipe_row_raw - ROW_WRAP;
   end

   // DrawY*640 as DrawY*512 + DrawY*128.
   assign bgd_lin = {DrawY, 9'b0} + {2'b00, DrawY, 7'b0} + {9'b0, DrawX};

   sprite_hit #(.W(BIRD_W), .H(BIRD_H), .ADDR_W(11)) u_bird_hit (
      .pos_x (pos_x),
      .pos_y (pos_y),
      .org_x ($signed({2'b00, BirdX})),
      .org_y ($signed({3'b000, BirdY})),
      .hit   (bird_hit),
      .addr  (bird_lin)
   );

   sprite_hit #(.W(PIPE_W), .H(PIPE_H), .ADDR_W(16)) u_pipe_hit (
      .pos_x (pos_x),
      .pos_y (pipe_row),
      .org_x ($signed({PipeX[10], PipeX})),
      .org_y (12'sd0),
      .hit   (pipe_hit),
      .addr  (pipe_lin)
   );

   sprite_hit #(.W(START_W), .H(START_H), .ADDR_W(13)) u_start_hit (
      .pos_x (pos_x),
      .pos_y (pos_y),
      .org_x (12'(START_X)),
      .org_y (12'(START_Y)),
      .hit   (start_hit),
      .addr  (start_lin)
   );

   sprite_hit #(.W(END_W), .H(END_H), .ADDR_W(14)) u_end_hit (
      .pos_x (pos_x),
      .pos_y (pos_y),
      .org_x (12'(END_X)),
      .org_y (12'(END_Y)),
      .hit   (end_hit),
      .addr  (end_lin)
   );

`ifdef SPRITE_COMP_FLASH_EN
   logic [4:0] flash_cnt;

   always_ff @(posedge Clk) begin
      if (!Reset_n)
         flash_cnt <= '0;
      else if (pixel_valid && (DrawX == 10'd0) && (DrawY == 10'd0))
         flash_cnt <= flash_cnt + 5'd1;
   end

   assign end_show = ~flash_cnt[4];
`else
   assign end_show = 1'b1;
`endif

   assign start_on = start_hit && (game_state == GS_START);
   assign end_on   = end_hit && (game_state == GS_OVER) && end_show;

   logic vld_p0, bird_hit_p0, pipe_hit_p0, start_hit_p0, end_hit_p0;
   logic vld_p1, bird_hit_p1, pipe_hit_p1, start_hit_p1, end_hit_p1;

   // S1: ROM addresses and hit flags
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         bird_addr    <= '0;
         bgd_addr     <= '0;
         pipe_addr    <= '0;
         start_addr   <= '0;
         end_addr     <= '0;
         vld_p0       <= 1'b0;
         bird_hit_p0  <= 1'b0;
         pipe_hit_p0  <= 1'b0;
         start_hit_p0 <= 1'b0;
         end_hit_p0   <= 1'b0;
      end else begin
         bird_addr    <= bird_lin;
         bgd_addr     <= bgd_lin;
         pipe_addr    <= pipe_lin;
         start_addr   <= start_on ? start_lin : '0;
         end_addr     <= end_on ? end_lin : '0;
         vld_p0       <= pixel_valid;
         bird_hit_p0  <= bird_hit;
         pipe_hit_p0  <= pipe_hit;
         start_hit_p0 <= start_on;
         end_hit_p0   <= end_on;
      end
   end

   // S2: flags wait one cycle for the ROM data of the same pixel
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         vld_p1       <= 1'b0;
         bird_hit_p1  <= 1'b0;
         pipe_hit_p1  <= 1'b0;
         start_hit_p1 <= 1'b0;
         end_hit_p1   <= 1'b0;
      end else begin
         vld_p1       <= vld_p0;
         bird_hit_p1  <= bird_hit_p0;
         pipe_hit_p1  <= pipe_hit_p0;
         start_hit_p1 <= start_hit_p0;
         end_hit_p1   <= end_hit_p0;
      end
   end

   logic [3:0]  idx;
   logic [23:0] colour;

   always_comb begin
      idx = bgd_data;
      if (end_hit_p1 && (end_data != 4'd0))
         idx = end_data;
      else if (start_hit_p1 && (start_data != 4'd0))
         idx = start_data;
      else if (bird_hit_p1 && (bird_data != 3'd0))
         idx = {1'b0, bird_data};
      else if (pipe_hit_p1 && (pipe_data != 4'd0))
         idx = pipe_data;
   end

   assign colour = PALETTE[idx];

   // S3: registered RGB
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         Red       <= '0;
         Green     <= '0;
         Blue      <= '0;
         rgb_valid <= 1'b0;
      end else begin
         Red       <= vld_p1 ? colour[23:16] : 8'd0;
         Green     <= vld_p1 ? colour[15:8]  : 8'd0;
         Blue      <= vld_p1 ? colour[7:0]   : 8'd0;
         rgb_valid <= vld_p1;
      end
   end

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: registered ROM model plus cycle-tagged scoreboard
// checking ROM addresses one cycle and RGB three cycles after each driven pixel.
`timescale 1ns/1ps
module tb_sprite_compositor;

   logic               Clk = 1'b0;
   logic               Reset_n;
   logic [9:0]         DrawX, DrawY;
   logic               pixel_valid;
   logic [9:0]         BirdX;
   logic [8:0]         BirdY;
   logic signed [10:0] PipeX;
   logic [8:0]         GapY;
   logic [1:0]         game_state;
   logic [10:0]        bird_addr;
   logic [18:0]        bgd_addr;
   logic [15:0]        pipe_addr;
   logic [12:0]        start_addr;
   logic [13:0]        end_addr;
   logic [2:0]         bird_data  = '0;
   logic [3:0]         bgd_data   = '0;
   logic [3:0]         pipe_data  = '0;
   logic [3:0]         start_data = '0;
   logic [3:0]         end_data   = '0;
   logic [7:0]         Red, Green, Blue;
   logic               rgb_valid;
   logic               end_clear = 1'b0;

   localparam logic [23:0] PAL [16] = '{
      24'h000000, 24'hFFFFFF, 24'h70C5CE, 24'hDED895,
      24'h73BF2E, 24'hF8B733, 24'hE0802C, 24'hD8382E,
      24'h543847, 24'h558022, 24'h9CE659, 24'hFAFAFA,
      24'hFC3800, 24'h5EE270, 24'hE7E7E7, 24'h3B2C32
   };

   always #5 Clk = ~Clk;

   sprite_compositor dut (
      .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
      .pixel_valid(pixel_valid), .BirdX(BirdX), .BirdY(BirdY), .PipeX(PipeX),
      .GapY(GapY), .game_state(game_state), .bird_addr(bird_addr),
      .bgd_addr(bgd_addr), .pipe_addr(pipe_addr), .start_addr(start_addr),
      .end_addr(end_addr), .bird_data(bird_data), .bgd_data(bgd_data),
      .pipe_data(pipe_data), .start_data(start_data), .end_data(end_data),
      .Red(Red), .Green(Green), .Blue(Blue), .rgb_valid(rgb_valid)
   );

   function automatic logic [2:0] bird_rom(input logic [10:0] a);
      return a[2:0] ^ a[5:3] ^ 3'd5;
   endfunction
   function automatic logic [3:0] pipe_rom(input logic [15:0] a);
      return a[3:0] ^ a[7:4] ^ 4'd9;
   endfunction
   function automatic logic [3:0] start_rom(input logic [12:0] a);
      return a[3:0] ^ 4'd3;
   endfunction
   function automatic logic [3:0] end_rom(input logic [13:0] a);
      return end_clear ? 4'd0 : (a[3:0] | 4'd1);
   endfunction
   function automatic logic [3:0] bgd_rom(input logic [18:0] a);
      return a[3:0] ^ a[11:8];
   endfunction

   always @(posedge Clk) begin
      bird_data  <= bird_rom(bird_addr);
      pipe_data  <= pipe_rom(pipe_addr);
      start_data <= start_rom(start_addr);
      end_data   <= end_rom(end_addr);
      bgd_data   <= bgd_rom(bgd_addr);
   end

   typedef struct {
      int          cyc;
      bit          chk;
      logic [10:0] ba;
      logic [18:0] ga;
      logic [15:0] pa;
      logic [12:0] sa;
      logic [13:0] ea;
   } addr_exp_t;

   typedef struct {
      int          cyc;
      logic [23:0] rgb;
      logic        rv;
   } rgb_exp_t;

   addr_exp_t  addr_q[$];
   rgb_exp_t   rgb_q[$];
   int         cycle    = 0;
   int         checks   = 0;
   int         failures = 0;
   logic [4:0] flash_model = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cycle, got, exp);
      end
   endtask

   task automatic push_expected();
      addr_exp_t   a;
      rgb_exp_t    r;
      int          x, y, bc, br, pc, pr, sc, sr, ec, er;
      bit          bh, ph, sh, eh, show;
      logic [3:0]  idx;
      a.cyc = cycle;
      r.cyc = cycle;
      if (!Reset_n) begin
         a.chk = 1'b1; a.ba = '0; a.ga = '0; a.pa = '0; a.sa = '0; a.ea = '0;
         r.rgb = '0; r.rv = 1'b0;
         foreach (rgb_q[i]) begin
            rgb_q[i].rgb = '0;
            rgb_q[i].rv  = 1'b0;
         end
         flash_model = '0;
      end else begin
         x  = int'(DrawX);
         y  = int'(DrawY);
         bc = x - int'(BirdX);
         br = y - int'(BirdY);
         bh = (bc >= 0) && (bc < 40) && (br >= 0) && (br < 40);
         pc = x - int'(PipeX);
         pr = ((y + 240 - int'(GapY)) % 480 + 480) % 480;
         ph = (pc >= 0) && (pc < 80);
         sc = x - 250;
         sr = y - 100;
         sh = (game_state == 2'd0) && (sc >= 0) && (sc < 140) && (sr >= 0) && (sr < 40);
         show = 1'b1;
`ifdef SPRITE_COMP_FLASH_EN
         show = !flash_model[4];
         if (pixel_valid && x == 0 && y == 0) flash_model = flash_model + 5'd1;
`endif
         ec = x - 205;
         er = y - 200;
         eh = (game_state == 2'd2) && show && (ec >= 0) && (ec < 230) && (er >= 0) && (er < 40);
         a.chk = pixel_valid;
         a.ba  = bh ? 11'(br * 40 + bc) : '0;
         a.pa  = ph ? 16'(pr * 80 + pc) : '0;
         a.sa  = sh ? 13'(sr * 140 + sc) : '0;
         a.ea  = eh ? 14'(er * 230 + ec) : '0;
         a.ga  = 19'(y * 640 + x);
         idx = bgd_rom(a.ga);
         if (ph && pipe_rom(a.pa) != 4'd0) idx = pipe_rom(a.pa);
         if (bh && bird_rom(a.ba) != 3'd0) idx = {1'b0, bird_rom(a.ba)};
         if (sh && start_rom(a.sa) != 4'd0) idx = start_rom(a.sa);
         if (eh && end_rom(a.ea) != 4'd0) idx = end_rom(a.ea);
         r.rv  = pixel_valid;
         r.rgb = pixel_valid ? PAL[idx] : 24'h0;
      end
      addr_q.push_back(a);
      rgb_q.push_back(r);
   endtask

   task automatic step();
      addr_exp_t a;
      rgb_exp_t  r;
      push_expected();
      @(negedge Clk);
      cycle++;
      if (addr_q.size() > 0 && addr_q[0].cyc == cycle - 1) begin
         a = addr_q.pop_front();
         if (a.chk) begin
            check("bird_addr",  32'(bird_addr),  32'(a.ba));
            check("bgd_addr",   32'(bgd_addr),   32'(a.ga));
            check("pipe_addr",  32'(pipe_addr),  32'(a.pa));
            check("start_addr", 32'(start_addr), 32'(a.sa));
            check("end_addr",   32'(end_addr),   32'(a.ea));
         end
      end
      if (rgb_q.size() > 0 && rgb_q[0].cyc == cycle - 3) begin
         r = rgb_q.pop_front();
         check("rgb",       {8'h00, Red, Green, Blue}, {8'h00, r.rgb});
         check("rgb_valid", 32'(rgb_valid),            32'(r.rv));
      end
   endtask

   task automatic px(input int x, input int y);
      DrawX = 10'(x);
      DrawY = 10'(y);
      pixel_valid = 1'b1;
      step();
   endtask

   task automatic idle(input int n);
      pixel_valid = 1'b0;
      repeat (n) step();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog cycle=%0d", cycle);
      $fatal(1);
   end

   initial begin
      Reset_n = 1'b0;
      DrawX = '0; DrawY = '0; pixel_valid = 1'b0;
      BirdX = 10'd100; BirdY = 9'd200; PipeX = 11'sd400; GapY = 9'd240;
      game_state = 2'd1;

      // reset holds everything at zero even with a valid bird pixel offered
      idle(2);
      px(100, 200);
      step();
      Reset_n = 1'b1;

      // bird corners and edges in PLAY
      px(100, 200); px(139, 239); px(140, 239); px(120, 220);
      px(99, 200);  px(100, 199); px(110, 230);
      DrawX = 10'd100; DrawY = 10'd200; pixel_valid = 1'b0; step();

      // pipe edges and gap wrap
      PipeX = -11'sd40; GapY = 9'd240; px(0, 0); px(39, 5); px(0, 300);
      PipeX = -11'sd80; px(0, 0); px(5, 5);
      PipeX = -11'sd40; GapY = 9'd400; px(10, 0);
      GapY = 9'd10; px(10, 470);
      PipeX = 11'sd600; px(639, 479); px(599, 10); px(600, 10);

      // start banner, including transparent banner texels over the bird
      game_state = 2'd0; BirdX = 10'd260; BirdY = 9'd110;
      px(250, 100); px(389, 139); px(390, 139); px(249, 100);
      for (int i = 0; i < 6; i++) px(263 + i, 115);

      // end banner, then transparent end banner over the bird
      game_state = 2'd2; BirdX = 10'd220; BirdY = 9'd210;
      px(205, 200); px(434, 239); px(435, 239); px(204, 200); px(225, 215);
      idle(3);
      end_clear = 1'b1;
      px(225, 215); px(226, 216); px(300, 230);
      idle(3);
      end_clear = 1'b0;

      // per-pixel state change
      game_state = 2'd0; px(300, 120);
      game_state = 2'd2; px(300, 210);
      game_state = 2'd1; px(300, 120);

      // randomised pixels biased toward sprite areas
      for (int i = 0; i < 200; i++) begin
         int sel;
         game_state  = 2'($urandom_range(2));
         BirdX       = 10'($urandom_range(600));
         BirdY       = 9'($urandom_range(440));
         PipeX       = 11'(int'($urandom_range(719)) - 80);
         GapY        = 9'($urandom_range(479));
         sel         = int'($urandom_range(3));
         pixel_valid = ($urandom_range(9) != 0);
         case (sel)
            0:       begin DrawX = 10'($urandom_range(639)); DrawY = 10'($urandom_range(479)); end
            1:       begin DrawX = 10'(int'(BirdX) + int'($urandom_range(45))); DrawY = 10'(int'(BirdY) + int'($urandom_range(45))); end
            2:       begin DrawX = 10'(245 + int'($urandom_range(150))); DrawY = 10'(95 + int'($urandom_range(50))); end
            default: begin DrawX = 10'(200 + int'($urandom_range(240))); DrawY = 10'(195 + int'($urandom_range(50))); end
         endcase
         step();
      end

      // reset while pixels are in flight
      game_state = 2'd1; BirdX = 10'd100; BirdY = 9'd200; PipeX = 11'sd110; GapY = 9'd240;
      for (int i = 0; i < 6; i++) px(100 + i * 3, 205);
      Reset_n = 1'b0;
      px(120, 220);
      Reset_n = 1'b1;
      for (int i = 0; i < 6; i++) px(101 + i * 5, 210);

      // frame-start counting against the end banner
      Reset_n = 1'b0;
      idle(1);
      Reset_n = 1'b1;
      game_state = 2'd2;
      repeat (16) px(0, 0);
      px(300, 210);
      repeat (16) px(0, 0);
      px(300, 210);
      idle(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sprite_compositor.md
SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 SHALL have port Clk, input, 1, pixel clock; the single clock of the block.
REQ-002 SHALL have port Reset_n, input, 1, synchronous active-low reset.
REQ-003 SHALL have inputs DrawX and DrawY, each 10 bits, giving the current pixel (0..639, 0..479).
REQ-004 SHALL have input pixel_valid, 1 bit, high in the active region.
REQ-005 SHALL have input BirdX (10b) and BirdY (9b), the bird top-left corner.
REQ-006 SHALL have input PipeX, 11b signed, pipe left edge, range -80..639.
REQ-007 SHALL have input GapY, 9b, pipe gap centre row.
REQ-008 SHALL have input game_state, 2b: START=0, PLAY=1, OVER=2.
REQ-009 SHALL have outputs bird_addr (11b), bgd_addr (19b), pipe_addr (16b), start_addr (13b) and end_addr (14b) to the sprite ROMs.
REQ-010 SHALL have inputs bird_data (3b) and bgd_data, pipe_data, start_data, end_data (4b each); each is ROM data valid one Clk after its address.
REQ-011 SHALL have outputs Red, Green and Blue (8b each) and rgb_valid (1b).

Function
REQ-012 SHALL be a 3-stage pipeline: S1 registers addresses and hit flags, S2 receives ROM data, S3 registers RGB; DrawX/DrawY at cycle N produce RGB at cycle N+3.
REQ-013 SHALL pipeline pixel_valid and all hit flags alongside their data so each is aligned with the ROM data of the same pixel.
REQ-014 SHALL compute bgd_addr = DrawY*640 + DrawX using shift-add only (no multiplier), with a 19b result.
REQ-015 Bird hit SHALL be DrawX-BirdX in 0..39 and DrawY-BirdY in 0..39, compared at 11b so it never wraps; bird_addr = row*40 + col.
REQ-016 Pipe hit SHALL be DrawX-PipeX (12b signed) in 0..79; pipe row = (DrawY+240-GapY) mod 480, wrapped by a single conditional add or subtract of 480; pipe_addr = row*80 + col.
REQ-017 Start banner SHALL be 140x40 at (250,100), hit only when game_state=START.
REQ-018 End banner SHALL be 230x40 at (205,200), hit only when game_state=OVER.
REQ-019 With no hit, the address for that ROM SHALL be held at 0.
REQ-020 Palette index 0 of bird, pipe and banner data SHALL be transparent; background is always opaque.
REQ-021 Layer priority SHALL be banner > bird > pipe > background, using the first non-transparent hit layer.
REQ-022 Index-to-RGB SHALL use a 16-entry palette constant; bird 3b data is zero-extended.
REQ-023 If the delayed pixel_valid is low, RGB SHALL be 0 and rgb_valid 0.
REQ-024 game_state SHALL be sampled in S1 per pixel; a mid-frame change affects only pixels entering after it.

Reset
REQ-025 While Reset_n=0 at a Clk edge, all pipeline registers, ROM addresses, RGB, rgb_valid and the flash counter SHALL clear to 0.
REQ-026 Reset asserted mid-pipeline SHALL discard in-flight pixels; the first valid output appears 3 cycles after the first valid input following release.

Configuration
REQ-027 Macro SPRITE_COMP_FLASH_EN defined: a 5b frame counter SHALL increment when pixel_valid=1 and DrawX=0, DrawY=0, wrapping 31->0; the end banner SHALL be suppressed (transparent) while counter bit 4 = 1.
REQ-028 Macro SPRITE_COMP_FLASH_EN undefined: the counter SHALL not exist and the end banner SHALL always be shown in OVER.

Structure
REQ-029 Package sprite_pkg SHALL hold the game_state enum, sprite dimensions and positions, the screen constants 640/480 and the 16x24b palette.
REQ-030 Sub-module sprite_hit (generic rectangle hit test plus local row/col) SHALL be instantiated once per sprite layer.

Verification
REQ-031 PLAY, BirdX=100, BirdY=200, DrawX=100, DrawY=200, bird_data=5 -> bird_addr=0 at N+1; RGB=palette[5] at N+3.
REQ-032 DrawX=139, DrawY=239, same bird -> bird_addr=1599; DrawX=140 -> no bird hit, pipe/background shown.
REQ-033 PipeX=-40, GapY=240, DrawX=0, DrawY=0 -> pipe hit, pipe_addr=40; PipeX=-80 -> no hit at DrawX=0.
REQ-034 GapY=400, DrawY=0 -> pipe row 320; GapY=10, DrawY=470 -> row 220 (wrap).
REQ-035 OVER, end_data=0 over bird pixel -> bird colour shown; pixel_valid=0 -> RGB=0, rgb_valid=0 at N+3.
REQ-036 With SPRITE_COMP_FLASH_EN: 16 frame starts -> end banner hidden; 32 -> shown; Reset_n=0 mid-frame -> RGB=0 next cycle.
